motor_pwm_slave: RTL and testbench

//  Avalon-MM slave driving NUM_MOTORS H-bridge channels from one shared PWM timebase.

---
 rtl/motor_pwm_pkg.sv | 26 ++
 rtl/motor_pwm_slave_if.sv | 21 ++
 rtl/motor_pwm_channel.sv | 38 +++
 rtl/motor_pwm_slave.sv | 160 ++++++++++++++++
 tb/tb_motor_pwm_slave.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/motor_pwm_pkg.sv
// Shared constants for the motor PWM slave: register word addresses,
// STATUS/COMMIT bit positions and the per-motor GPIO nibble layout.
package motor_pwm_pkg;

    localparam logic [4:0] ADDR_CTRL      = 5'h00;
    localparam logic [4:0] ADDR_DUTY      = 5'h08;
    localparam logic [4:0] ADDR_PERIOD    = 5'h10;
    localparam logic [4:0] ADDR_COMMIT    = 5'h11;
    localparam logic [4:0] ADDR_WDOG_LOAD = 5'h12;
    localparam logic [4:0] ADDR_STATUS    = 5'h13;

    localparam int STAT_PENDING = 0;
    localparam int STAT_TRIP    = 1;
    localparam int COMMIT_BIT   = 0;

    localparam int GPIO_PWM_A = 0;
    localparam int GPIO_PWM_B = 1;
    localparam int GPIO_EN    = 2;
    localparam int GPIO_DIR   = 3;

    typedef struct packed {
        logic dir;
        logic en;
    } motor_ctrl_t;

endpackage

// File: rtl/motor_pwm_slave_if.sv
// Avalon-MM slave bus bundle for the motor PWM block.
interface motor_pwm_slave_if;

    logic        chipselect;
    logic        write;
    logic        read;
    logic [4:0]  addr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect, write, read, addr, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, write, read, addr, writedata,
        output readdata
    );

endinterface

// File: rtl/motor_pwm_channel.sv
// One H-bridge channel: compares the shared counter against its active duty
// and registers the {dir, en, pwm_b, pwm_a} nibble, with a forced-off kill.
module motor_pwm_channel #(
    parameter int PWM_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [PWM_WIDTH-1:0] cnt,
    input  logic [PWM_WIDTH-1:0] duty_a,
    input  logic                 en_a,
    input  logic                 dir_a,
    input  logic                 kill,
    output logic [3:0]           gpio
);
    import motor_pwm_pkg::*;

    logic       pwm;
    logic [3:0] nibble;

    always_comb begin
        pwm                = en_a & (cnt < duty_a);
        nibble             = '0;
        nibble[GPIO_PWM_A] = pwm & dir_a;
        nibble[GPIO_PWM_B] = pwm & ~dir_a;
        nibble[GPIO_EN]    = en_a;
        nibble[GPIO_DIR]   = dir_a;
    end

    // The kill gate sits on the register input so the pins drop on the next edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gpio <= '0;
        end else begin
            gpio <= kill ? 4'b0000 : nibble;
        end
    end

endmodule

// File: rtl/motor_pwm_slave.sv
// Avalon-MM slave driving NUM_MOTORS H-bridges from one PWM timebase, with
// double-buffered settings committed at period wrap and a host-activity watchdog.
module motor_pwm_slave #(
    parameter int NUM_MOTORS = 6,
    parameter int PWM_WIDTH  = 12,
    parameter int WDOG_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    reset_n,
    motor_pwm_slave_if.slave        bus,
    output logic                    wdog_trip,
    output logic [4*NUM_MOTORS-1:0] GPIO_out
);
    import motor_pwm_pkg::*;

    motor_ctrl_t            ctrl_s [NUM_MOTORS];
    motor_ctrl_t            ctrl_a [NUM_MOTORS];
    logic [PWM_WIDTH-1:0]   duty_s [NUM_MOTORS];
    logic [PWM_WIDTH-1:0]   duty_a [NUM_MOTORS];
    logic [PWM_WIDTH-1:0]   period_s;
    logic [PWM_WIDTH-1:0]   period_a;
    logic [PWM_WIDTH-1:0]   cnt;
    logic                   pending;
    logic [WDOG_WIDTH-1:0]  wdog_load;
    logic [WDOG_WIDTH-1:0]  wcnt;
    logic [31:0]            rd_mux;
    logic [3:0]             gpio_nib [NUM_MOTORS];

    logic wr;
    logic rd;
    logic period_zero;
    logic wrap;
    logic commit_fire;
    logic commit_req;
    logic status_clear;
    logic unused_wdata;

    assign wr           = bus.chipselect & bus.write;
    assign rd           = bus.chipselect & bus.read;
    assign period_zero  = (period_a == '0);
    assign wrap         = !period_zero && (cnt == period_a - PWM_WIDTH'(1));
    assign commit_fire  = pending && (period_zero || wrap);
    assign commit_req   = wr && (bus.addr == ADDR_COMMIT) && bus.writedata[COMMIT_BIT];
    assign status_clear = wr && (bus.addr == ADDR_STATUS) && bus.writedata[STAT_TRIP];
    assign unused_wdata = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                ctrl_s[i] <= '0;
                duty_s[i] <= '0;
            end
            period_s  <= '0;
            wdog_load <= '0;
        end else if (wr) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                if (bus.addr == ADDR_CTRL + 5'(i)) ctrl_s[i] <= bus.writedata[1:0];
                if (bus.addr == ADDR_DUTY + 5'(i)) duty_s[i] <= bus.writedata[PWM_WIDTH-1:0];
            end
            if (bus.addr == ADDR_PERIOD)    period_s  <= bus.writedata[PWM_WIDTH-1:0];
            if (bus.addr == ADDR_WDOG_LOAD) wdog_load <= bus.writedata[WDOG_WIDTH-1:0];
        end
    end

    // Non-blocking loads mean the active set takes the shadow values held before the wrap edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                ctrl_a[i] <= '0;
                duty_a[i] <= '0;
            end
            period_a <= '0;
        end else if (commit_fire) begin
            ctrl_a   <= ctrl_s;
            duty_a   <= duty_s;
            period_a <= period_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (period_zero || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PWM_WIDTH'(1);
        end
    end

    // A COMMIT write outranks the clear, so one landing in the wrap cycle applies next wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
        end else if (commit_req) begin
            pending <= 1'b1;
        end else if (commit_fire) begin
            pending <= 1'b0;
        end
    end

    // Expiry is only reachable on write-free cycles, so a STATUS clear always beats it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt      <= '0;
            wdog_trip <= 1'b0;
        end else begin
            if (wr) begin
                wcnt <= (bus.addr == ADDR_WDOG_LOAD) ? bus.writedata[WDOG_WIDTH-1:0] : wdog_load;
            end else if (wdog_load != '0 && wcnt != '0) begin
                wcnt <= wcnt - WDOG_WIDTH'(1);
            end

            if (status_clear) begin
                wdog_trip <= 1'b0;
            end else if (!wr && wdog_load != '0 && wcnt == WDOG_WIDTH'(1)) begin
                wdog_trip <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            if (bus.addr == ADDR_CTRL + 5'(i)) rd_mux = {30'b0, ctrl_s[i]};
            if (bus.addr == ADDR_DUTY + 5'(i)) rd_mux = 32'(duty_s[i]);
        end
        if (bus.addr == ADDR_PERIOD)    rd_mux = 32'(period_s);
        if (bus.addr == ADDR_WDOG_LOAD) rd_mux = 32'(wdog_load);
        if (bus.addr == ADDR_STATUS) begin
            rd_mux[STAT_PENDING] = pending;
            rd_mux[STAT_TRIP]    = wdog_trip;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else if (rd) begin
            bus.readdata <= rd_mux;
        end
    end

    // A zero period must silence every pwm even though cnt sits at 0.
    for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_motor
        motor_pwm_channel #(
            .PWM_WIDTH (PWM_WIDTH)
        ) u_channel (
            .clk     (clk),
            .reset_n (reset_n),
            .cnt     (cnt),
            .duty_a  (period_zero ? {PWM_WIDTH{1'b0}} : duty_a[g]),
            .en_a    (ctrl_a[g].en),
            .dir_a   (ctrl_a[g].dir),
            .kill    (wdog_trip),
            .gpio    (gpio_nib[g])
        );
        assign GPIO_out[4*g +: 4] = gpio_nib[g];
    end

endmodule

// File: tb/tb_motor_pwm_slave.sv
// Self-checking bench for motor_pwm_slave: directed scenarios plus random bus
// traffic, all compared against a cycle-level behavioural model of the register map.
module tb_motor_pwm_slave;

    localparam int NM = 6;

    logic            clk;
    logic            reset_n;
    logic            wdog_trip;
    logic [4*NM-1:0] GPIO_out;

    motor_pwm_slave_if bus();

    motor_pwm_slave #(
        .NUM_MOTORS (NM),
        .PWM_WIDTH  (12),
        .WDOG_WIDTH (24)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .wdog_trip (wdog_trip),
        .GPIO_out  (GPIO_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: per-motor settings as plain integers, position within the
    // period, and the watchdog expressed as "cycles since the last host write".
    int              sh_ctrl [8];
    int              sh_duty [8];
    int              ac_ctrl [8];
    int              ac_duty [8];
    int              sh_period;
    int              ac_period;
    int              phase;
    bit              pend;
    int              wd_load;
    int              last_wr;
    int              cyc = 0;
    bit              trip_m;
    logic [4*NM-1:0] exp_gpio;
    logic [31:0]     exp_rdata;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 8; m++) begin
            sh_ctrl[m] = 0;
            sh_duty[m] = 0;
            ac_ctrl[m] = 0;
            ac_duty[m] = 0;
        end
        sh_period = 0;
        ac_period = 0;
        phase     = 0;
        pend      = 0;
        wd_load   = 0;
        last_wr   = cyc;
        trip_m    = 0;
        exp_gpio  = '0;
        exp_rdata = '0;
    endtask

    function automatic int regValue(input int a);
        if (a < NM)                  return sh_ctrl[a];
        if (a >= 8 && a < 8 + NM)    return sh_duty[a-8];
        if (a == 16)                 return sh_period;
        if (a == 18)                 return wd_load;
        if (a == 19)                 return (int'(trip_m) << 1) | int'(pend);
        return 0;
    endfunction

    task automatic modelStep();
        bit              wr;
        bit              rd;
        bit              commit_now;
        bit              on;
        bit              dr;
        int              a;
        int              d;
        logic [4*NM-1:0] nxt;
        wr  = bus.chipselect && bus.write;
        rd  = bus.chipselect && bus.read;
        a   = int'(bus.addr);
        d   = int'(bus.writedata);
        nxt = '0;
        for (int m = 0; m < NM; m++) begin
            dr = ac_ctrl[m][1];
            on = ac_ctrl[m][0] && (ac_period > 0) && (phase < ac_duty[m]);
            if (!trip_m) begin
                nxt[4*m]   = on && dr;
                nxt[4*m+1] = on && !dr;
                nxt[4*m+2] = ac_ctrl[m][0];
                nxt[4*m+3] = dr;
            end
        end
        if (rd) exp_rdata = regValue(a);
        commit_now = pend && (ac_period == 0 || phase == ac_period - 1);
        phase = (ac_period == 0) ? 0 : (phase + 1) % ac_period;
        if (commit_now) begin
            ac_ctrl   = sh_ctrl;
            ac_duty   = sh_duty;
            ac_period = sh_period;
        end
        cyc++;
        if (wr) begin
            if (a < NM)                     sh_ctrl[a]   = d & 3;
            else if (a >= 8 && a < 8 + NM)  sh_duty[a-8] = d & 'hFFF;
            else if (a == 16)               sh_period    = d & 'hFFF;
            else if (a == 18)               wd_load      = d & 'hFFFFFF;
            if (a == 17 && d[0]) pend = 1;
            else if (commit_now) pend = 0;
            if (a == 19 && d[1]) trip_m = 0;
            last_wr = cyc;
        end else begin
            if (commit_now) pend = 0;
            if (wd_load != 0 && cyc - last_wr == wd_load) trip_m = 1;
        end
        exp_gpio = nxt;
    endtask

    always @(posedge clk) begin
        if (!reset_n) modelReset();
        else          modelStep();
    end

    always @(negedge reset_n) modelReset();

    always @(negedge clk) begin
        checkOutput("gpio", 32'(GPIO_out), 32'(exp_gpio));
        checkOutput("trip", 32'(wdog_trip), 32'(trip_m));
        checkOutput("rdata", bus.readdata, exp_rdata);
    end

    task automatic applyStimulus(input bit cs, input bit we, input bit re, input logic [4:0] a, input logic [31:0] d);
        bus.chipselect = cs;
        bus.write      = we;
        bus.read       = re;
        bus.addr       = a;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
    endtask

    task automatic writeReg(input int a, input int d);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'(a), 32'(d));
    endtask

    task automatic readReg(input int a);
        applyStimulus(1'b1, 1'b0, 1'b1, 5'(a), 32'h0);
    endtask

    task automatic waitPhase(input int target);
        for (int k = 0; k < 200 && phase != target; k++) @(negedge clk);
        if (phase != target) begin
            checkCount++;
            $display("[TB] FAIL wait_phase: got %0d expected %0d (timeout)", phase, target);
        end
    endtask

    task automatic countHigh(input int bitA, input int bitB, output int na, output int nb);
        na = 0;
        nb = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            na += int'(GPIO_out[bitA]);
            nb += int'(GPIO_out[bitB]);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int na;
        int nb;
        int anyPwm;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.addr       = '0;
        bus.writedata  = '0;
        reset_n        = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] reset readback");
        checkOutput("rst_gpio", 32'(GPIO_out), 32'h0);
        checkOutput("rst_trip", 32'(wdog_trip), 32'h0);
        for (int a = 0; a < 32; a++) begin
            readReg(a);
            checkOutput("rst_read", bus.readdata, 32'h0);
        end

        $display("[TB] first commit, period 10 duty 3");
        writeReg(16, 10);
        writeReg(8, 3);
        writeReg(0, 3);
        writeReg(17, 1);
        repeat (25) @(negedge clk);
        countHigh(0, 1, na, nb);
        checkOutput("duty3_pwm_a", 32'(na), 32'd3);
        checkOutput("duty3_pwm_b", 32'(nb), 32'd0);

        $display("[TB] mid-period commit");
        waitPhase(2);
        writeReg(8, 7);
        writeReg(0, 1);
        writeReg(17, 1);
        repeat (25) @(negedge clk);
        countHigh(0, 1, na, nb);
        checkOutput("duty7_pwm_a", 32'(na), 32'd0);
        checkOutput("duty7_pwm_b", 32'(nb), 32'd7);

        $display("[TB] commit written in the wrap cycle");
        writeReg(8, 2);
        writeReg(0, 3);
        waitPhase(9);
        writeReg(17, 1);
        countHigh(0, 1, na, nb);
        checkOutput("wrapc_old_a", 32'(na), 32'd0);
        checkOutput("wrapc_old_b", 32'(nb), 32'd7);
        countHigh(0, 1, na, nb);
        checkOutput("wrapc_new_a", 32'(na), 32'd2);
        checkOutput("wrapc_new_b", 32'(nb), 32'd0);

        $display("[TB] duty extremes and zero period");
        writeReg(1, 1);
        writeReg(9, 0);
        writeReg(17, 1);
        repeat (25) @(negedge clk);
        countHigh(5, 4, na, nb);
        checkOutput("duty0_pwm_b", 32'(na), 32'd0);
        writeReg(9, 15);
        writeReg(17, 1);
        repeat (25) @(negedge clk);
        countHigh(5, 4, na, nb);
        checkOutput("duty15_pwm_b", 32'(na), 32'd10);
        writeReg(16, 0);
        writeReg(17, 1);
        repeat (25) @(negedge clk);
        anyPwm = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            for (int m = 0; m < NM; m++) anyPwm += int'(GPIO_out[4*m]) + int'(GPIO_out[4*m+1]);
        end
        checkOutput("period0_pwm", 32'(anyPwm), 32'd0);

        $display("[TB] watchdog expiry and clear");
        writeReg(16, 10);
        writeReg(17, 1);
        repeat (25) @(negedge clk);
        writeReg(18, 50);
        repeat (49) @(negedge clk);
        checkOutput("wdog_before", 32'(wdog_trip), 32'd0);
        @(negedge clk);
        checkOutput("wdog_trip", 32'(wdog_trip), 32'd1);
        @(negedge clk);
        checkOutput("wdog_gpio_off", 32'(GPIO_out), 32'h0);
        writeReg(19, 2);
        checkOutput("wdog_cleared", 32'(wdog_trip), 32'd0);
        @(negedge clk);
        checkOutput("wdog_resume_en0", 32'(GPIO_out[2]), 32'd1);
        writeReg(18, 0);

        $display("[TB] random bus traffic");
        for (int n = 0; n < 400; n++) begin
            int op;
            int a;
            int d;
            op = $urandom_range(0, 3);
            a  = $urandom_range(0, 31);
            d  = $urandom_range(0, 15);
            if (op == 0 && $urandom_range(0, 3) == 0) a = 17;
            case (op)
                0:       writeReg(a, d);
                1:       readReg(a);
                default: @(negedge clk);
            endcase
        end

        $display("[TB] asynchronous reset mid-period");
        writeReg(18, 0);
        writeReg(19, 2);
        writeReg(16, 10);
        writeReg(8, 5);
        writeReg(0, 3);
        writeReg(17, 1);
        repeat (25) @(negedge clk);
        checkOutput("pre_rst_en0", 32'(GPIO_out[2]), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst_gpio", 32'(GPIO_out), 32'h0);
        checkOutput("arst_trip", 32'(wdog_trip), 32'h0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        writeReg(6, 3);
        readReg(6);
        checkOutput("ctrl6_ignored", bus.readdata, 32'h0);
        writeReg(14, 9);
        readReg(14);
        checkOutput("duty6_ignored", bus.readdata, 32'h0);
        readReg(16);
        checkOutput("period_after_rst", bus.readdata, 32'h0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
